// File: rtl/spi_slave_pkg.sv
// Shared types, constants and bit-order helpers for the SPI slave receiver.
package spi_slave_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2
    } state_t;

    localparam int SYNC_STAGES = 2;
    localparam int BIT_CNT_W   = 3;

    // Next bit to leave the slave for the selected bit order.
    function automatic logic out_bit(input logic [7:0] b, input logic msb);
        return msb ? b[7] : b[0];
    endfunction

    function automatic logic [7:0] shift_out(input logic [7:0] b, input logic msb);
        return msb ? {b[6:0], 1'b0} : {1'b0, b[7:1]};
    endfunction

    function automatic logic [7:0] shift_in(input logic [7:0] b, input logic d, input logic msb);
        return msb ? {b[6:0], d} : {d, b[7:1]};
    endfunction

endpackage

// File: rtl/spi_rx_fifo.sv
// First-word fall-through byte FIFO; head reads as zero while empty.
module spi_rx_fifo #(
    parameter int DEPTH = 16
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic       push,
    input  logic [7:0] push_data,
    input  logic       pop,
    output logic [7:0] head,
    output logic       valid,
    output logic       full
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]  mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        do_pop;
    logic        do_push;

    assign valid   = (wr_ptr != rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && valid;
    assign do_push = push && (!full || do_pop);
    assign head    = valid ? mem[rd_ptr[AW-1:0]] : 8'h00;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // NOTE: storage has no reset; the pointers alone define which entries are meaningful.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/spi_slave_rx.sv
// SPI slave oversampled in the clk domain: receives MOSI bytes into a FIFO and replies on MISO.
module spi_slave_rx
    import spi_slave_pkg::*;
#(
    parameter int         FIFO_DEPTH = 16,
    parameter logic [7:0] FILL_BYTE  = 8'hFF
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic       spi_clk,
    input  logic       spi_mosi,
    input  logic       spi_cs_n,
    output logic       spi_miso,
    input  logic       cpol,
    input  logic       cpha,
    input  logic       msb_first,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       rx_overflow,
    output logic       tx_underrun,
    input  logic       status_clr,
    output logic       frame_active
);

    logic [SYNC_STAGES-1:0] sclk_sync, mosi_sync, cs_sync;
    logic sclk_prev, cs_prev;
    logic sclk_s, mosi_s, cs_s, cs_fall;
    logic sclk_rise, sclk_fall, lead_edge, trail_edge, sample_edge, shift_edge;
    logic cpol_q, cpha_q, msb_q;

    state_t state, state_next;
    logic [BIT_CNT_W-1:0] bit_cnt;
    logic [7:0] rx_sr, tx_sr, tx_hold, tx_load;
    logic tx_full, push_pending, fifo_full, overflow_evt, underrun_evt;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            sclk_sync <= '0;
            mosi_sync <= '0;
            cs_sync   <= '1;
            sclk_prev <= 1'b0;
            cs_prev   <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_clk};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
            sclk_prev <= sclk_s;
            cs_prev   <= cs_s;
        end
    end

    assign sclk_s  = sclk_sync[SYNC_STAGES-1];
    assign mosi_s  = mosi_sync[SYNC_STAGES-1];
    assign cs_s    = cs_sync[SYNC_STAGES-1];
    assign cs_fall = cs_prev && !cs_s;

    // Mode is frozen for the whole frame once chip select drops.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            cpol_q <= 1'b0;
            cpha_q <= 1'b0;
            msb_q  <= 1'b0;
        end else if (cs_s) begin
            cpol_q <= cpol;
            cpha_q <= cpha;
            msb_q  <= msb_first;
        end
    end

    assign sclk_rise   = sclk_s && !sclk_prev;
    assign sclk_fall   = !sclk_s && sclk_prev;
    assign lead_edge   = cpol_q ? sclk_fall : sclk_rise;
    assign trail_edge  = cpol_q ? sclk_rise : sclk_fall;
    assign sample_edge = cpha_q ? trail_edge : lead_edge;
    assign shift_edge  = cpha_q ? lead_edge : trail_edge;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) state <= ST_IDLE;
        else       state <= state_next;
    end

    // NOTE: defaults first so every path assigns each output and no latch is inferred.
    always_comb begin
        state_next   = state;
        frame_active = 1'b0;
        case (state)
            ST_IDLE:  if (cs_fall) state_next = ST_LOAD;
            ST_LOAD:  begin
                frame_active = 1'b1;
                state_next   = ST_SHIFT;
            end
            ST_SHIFT: begin
                frame_active = 1'b1;
                if (sample_edge && bit_cnt == '1) state_next = ST_LOAD;
            end
            default:  state_next = ST_IDLE;
        endcase
        if (cs_s) state_next = ST_IDLE;
    end

    assign tx_load      = tx_full ? tx_hold : FILL_BYTE;
    assign tx_ready     = !tx_full;
    assign underrun_evt = (state == ST_LOAD) && !tx_full;
    assign overflow_evt = push_pending && fifo_full && !(rx_valid && rx_ready);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            tx_hold <= 8'h00;
            tx_full <= 1'b0;
        end else if (tx_valid && tx_ready) begin
            tx_hold <= tx_data;
            tx_full <= 1'b1;
        end else if (state == ST_LOAD) begin
            tx_full <= 1'b0;
        end
    end

    // A shift edge with bit_cnt==0 is the byte's first MISO bit for cpha=1, and the
    // trailing edge of the previous byte's last clock for cpha=0 (already driven in LOAD).
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            bit_cnt      <= '0;
            rx_sr        <= 8'h00;
            tx_sr        <= 8'h00;
            spi_miso     <= 1'b1;
            push_pending <= 1'b0;
        end else begin
            push_pending <= 1'b0;
            case (state)
                ST_LOAD: begin
                    tx_sr <= tx_load;
                    if (!cpha_q) spi_miso <= out_bit(tx_load, msb_q);
                end
                ST_SHIFT: begin
                    if (sample_edge) begin
                        rx_sr   <= shift_in(rx_sr, mosi_s, msb_q);
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == '1) push_pending <= 1'b1;
                    end
                    if (shift_edge && bit_cnt != '0) begin
                        tx_sr    <= shift_out(tx_sr, msb_q);
                        spi_miso <= out_bit(shift_out(tx_sr, msb_q), msb_q);
                    end else if (shift_edge && cpha_q) begin
                        spi_miso <= out_bit(tx_sr, msb_q);
                    end
                end
                default: begin
                    bit_cnt  <= '0;
                    spi_miso <= 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            rx_overflow <= 1'b0;
            tx_underrun <= 1'b0;
        end else begin
            if (overflow_evt)    rx_overflow <= 1'b1;
            else if (status_clr) rx_overflow <= 1'b0;
            if (underrun_evt)    tx_underrun <= 1'b1;
            else if (status_clr) tx_underrun <= 1'b0;
        end
    end

    spi_rx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .nrst      (nrst),
        .push      (push_pending),
        .push_data (rx_sr),
        .pop       (rx_ready),
        .head      (rx_data),
        .valid     (rx_valid),
        .full      (fifo_full)
    );

endmodule

// File: tb/tb_spi_slave_rx.sv
// Directed bench: a behavioural SPI master drives the slave in several modes.
`timescale 1ns/1ps
module tb_spi_slave_rx;

    localparam int HALF = 80;

    logic       clk = 1'b0;
    logic       nrst = 1'b0;
    logic       spi_clk = 1'b0, spi_mosi = 1'b0, spi_cs_n = 1'b1;
    logic       spi_miso;
    logic       cpol = 1'b0, cpha = 1'b0, msb_first = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       rx_overflow, tx_underrun;
    logic       status_clr = 1'b0;
    logic       frame_active;

    int checks = 0;
    int errors = 0;
    logic [7:0] m_tx [8];
    logic [7:0] m_rx [8];

    always #5 clk = ~clk;

    spi_slave_rx #(.FIFO_DEPTH(4), .FILL_BYTE(8'hFF)) dut (
        .clk(clk), .nrst(nrst), .spi_clk(spi_clk), .spi_mosi(spi_mosi),
        .spi_cs_n(spi_cs_n), .spi_miso(spi_miso), .cpol(cpol), .cpha(cpha),
        .msb_first(msb_first), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .rx_overflow(rx_overflow), .tx_underrun(tx_underrun),
        .status_clr(status_clr), .frame_active(frame_active)
    );

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h", tag, got, exp);
        end
    endtask

    task automatic set_mode(input logic pol, input logic pha, input logic msb);
        @(negedge clk);
        cpol = pol; cpha = pha; msb_first = msb; spi_clk = pol;
        repeat (6) @(negedge clk);
    endtask

    // Master side of one byte (or fewer bits); bit order follows msb_first.
    task automatic xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        int idx;
        rx = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            idx = msb_first ? 7 - i : i;
            if (!cpha) begin
                spi_mosi = tx[idx];
                #HALF spi_clk = ~cpol; rx[idx] = spi_miso;
                #HALF spi_clk = cpol;
            end else begin
                spi_clk = ~cpol; spi_mosi = tx[idx];
                #HALF spi_clk = cpol; rx[idx] = spi_miso;
                #HALF;
            end
        end
    endtask

    task automatic frame(input int n);
        @(negedge clk);
        spi_cs_n = 1'b0;
        for (int i = 0; i < n; i++) xfer(m_tx[i], 8, m_rx[i]);
        #HALF spi_cs_n = 1'b1;
        repeat (20) @(negedge clk);
    endtask

    task automatic queue_tx(input logic [7:0] b);
        @(negedge clk);
        check("tx_ready_before_queue", 8'(tx_ready), 8'h01);
        tx_data = b; tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        check("tx_ready_after_queue", 8'(tx_ready), 8'h00);
    endtask

    task automatic pop_expect(input string tag, input logic [7:0] exp);
        @(negedge clk);
        check({tag, "_valid"}, 8'(rx_valid), 8'h01);
        check(tag, rx_data, exp);
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
    endtask

    task automatic clear_status;
        @(negedge clk);
        status_clr = 1'b1;
        @(negedge clk);
        status_clr = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_rx_valid", 8'(rx_valid), 8'h00);
        check("rst_rx_data", rx_data, 8'h00);
        check("rst_tx_ready", 8'(tx_ready), 8'h01);
        check("rst_miso", 8'(spi_miso), 8'h01);
        check("rst_overflow", 8'(rx_overflow), 8'h00);
        check("rst_underrun", 8'(tx_underrun), 8'h00);
        check("rst_frame_active", 8'(frame_active), 8'h00);
        nrst = 1'b1;
        repeat (4) @(negedge clk);

        // Mode 0, MSB first: 0xA5 in, 0x3C out
        set_mode(1'b0, 1'b0, 1'b1);
        queue_tx(8'h3C);
        m_tx[0] = 8'hA5;
        frame(1);
        check("m0_master_rx", m_rx[0], 8'h3C);
        check("m0_idle_miso", 8'(spi_miso), 8'h01);
        check("m0_idle_frame_active", 8'(frame_active), 8'h00);
        pop_expect("m0_rx", 8'hA5);
        @(negedge clk);
        check("m0_empty", 8'(rx_valid), 8'h00);
        clear_status;
        check("m0_underrun_cleared", 8'(tx_underrun), 8'h00);

        // Mode 3, LSB first, 3 bytes, nothing queued
        set_mode(1'b1, 1'b1, 1'b0);
        m_tx[0] = 8'h01; m_tx[1] = 8'h80; m_tx[2] = 8'hFF;
        frame(3);
        check("m3_master_rx0", m_rx[0], 8'hFF);
        check("m3_master_rx1", m_rx[1], 8'hFF);
        check("m3_master_rx2", m_rx[2], 8'hFF);
        check("m3_underrun", 8'(tx_underrun), 8'h01);
        pop_expect("m3_rx0", 8'h01);
        pop_expect("m3_rx1", 8'h80);
        pop_expect("m3_rx2", 8'hFF);
        clear_status;

        // Overflow: depth 4, five bytes, nobody popping
        set_mode(1'b0, 1'b0, 1'b1);
        m_tx[0] = 8'h11; m_tx[1] = 8'h22; m_tx[2] = 8'h33; m_tx[3] = 8'h44; m_tx[4] = 8'h55;
        frame(5);
        check("ovf_flag", 8'(rx_overflow), 8'h01);
        clear_status;
        check("ovf_cleared", 8'(rx_overflow), 8'h00);

        // status_clr held through the next overflowing push: set must win
        m_tx[0] = 8'h66;
        fork
            frame(1);
            begin
                status_clr = 1'b1;
                for (int i = 0; i < 400; i++) begin
                    @(negedge clk);
                    if (rx_overflow) break;
                end
                status_clr = 1'b0;
            end
        join
        check("ovf_set_beats_clr", 8'(rx_overflow), 8'h01);
        pop_expect("ovf_rx0", 8'h11);
        pop_expect("ovf_rx1", 8'h22);
        pop_expect("ovf_rx2", 8'h33);
        pop_expect("ovf_rx3", 8'h44);
        @(negedge clk);
        check("ovf_fifth_lost", 8'(rx_valid), 8'h00);
        clear_status;

        // Abort after 5 bits, then a clean 0x5A frame
        @(negedge clk);
        spi_cs_n = 1'b0;
        repeat (8) @(negedge clk);
        check("abort_frame_active", 8'(frame_active), 8'h01);
        xfer(8'hFF, 5, m_rx[7]);
        #HALF spi_cs_n = 1'b1;
        repeat (20) @(negedge clk);
        check("abort_idle", 8'(frame_active), 8'h00);
        check("abort_no_push", 8'(rx_valid), 8'h00);
        m_tx[0] = 8'h5A;
        frame(1);
        pop_expect("abort_rx", 8'h5A);
        @(negedge clk);
        check("abort_only_one", 8'(rx_valid), 8'h00);
        clear_status;

        // Mode 1: reset in the middle of a byte
        set_mode(1'b0, 1'b1, 1'b1);
        @(negedge clk);
        spi_cs_n = 1'b0;
        repeat (8) @(negedge clk);
        queue_tx(8'h77);
        xfer(8'hF0, 3, m_rx[7]);
        check("mid_underrun_pre", 8'(tx_underrun), 8'h01);
        nrst = 1'b0;
        #1;
        check("mid_rst_frame_active", 8'(frame_active), 8'h00);
        check("mid_rst_miso", 8'(spi_miso), 8'h01);
        check("mid_rst_tx_ready", 8'(tx_ready), 8'h01);
        check("mid_rst_underrun", 8'(tx_underrun), 8'h00);
        check("mid_rst_rx_valid", 8'(rx_valid), 8'h00);
        spi_cs_n = 1'b1; spi_clk = 1'b0;
        repeat (5) @(negedge clk);
        nrst = 1'b1;
        set_mode(1'b0, 1'b1, 1'b1);
        queue_tx(8'hC3);
        m_tx[0] = 8'h96;
        frame(1);
        check("m1_master_rx", m_rx[0], 8'hC3);
        pop_expect("m1_rx", 8'h96);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
